// File: rtl/soc_system_arg_pkg.sv
// soc_system_arg_pkg: shared defaults and FSM state type for the argument readers
package soc_system_arg_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/soc_system_arg_fifo.sv
// soc_system_arg_fifo: synchronous FIFO with occupancy count and flush, head visible on rdata
module soc_system_arg_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk)
    if (!reset_n || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/soc_system_arg_a_reader.sv
// soc_system_arg_a_reader: streams word_count RAM words from base_addr through an output FIFO
module soc_system_arg_a_reader
  import soc_system_arg_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_clken,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q, issued_q;
  logic              inflight_q, inflight_last_q;
  logic [CW-1:0]     fifo_count, fifo_count_d;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_empty, kill, issue, last_issue, push, pop;
  assign kill         = abort && (state_q == RUN || state_q == DRAIN);
  assign issue        = state_q == RUN && !kill && issued_q != cnt_q &&
                        (fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign last_issue   = issue && issued_q == cnt_q - 1'b1;
  assign fifo_empty   = fifo_count == '0;
  assign pop          = out_ready && !fifo_empty;
  assign push         = inflight_q && !(fifo_empty && out_ready);
  assign fifo_count_d = fifo_count + CW'(push) - CW'(pop);
  assign out_valid    = !fifo_empty || inflight_q;
  assign out_data     = fifo_empty ? ram_readdata : fifo_rdata[DATA_W-1:0];
  assign out_last     = fifo_empty ? inflight_last_q : fifo_rdata[DATA_W];
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_clken      = 1'b1;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  soc_system_arg_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (kill),
    .push    (push),
    .pop     (pop),
    .wdata   ({inflight_last_q, ram_readdata}),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      addr_q          <= (state_q == IDLE && start) ? base_addr : addr_q + ADDR_W'(issue);
      issued_q        <= (state_q == IDLE) ? '0 : issued_q + (ADDR_W+1)'(issue);
      cnt_q           <= (state_q == IDLE && start) ? (word_count > MAX_CNT ? MAX_CNT : word_count) : cnt_q;
      case (state_q)
        IDLE:    state_q <= !start ? IDLE : (word_count == '0 ? DONE : RUN);
        RUN:     state_q <= kill ? IDLE : (last_issue ? DRAIN : RUN);
        DRAIN:   state_q <= kill ? IDLE : (fifo_count_d == '0 ? DONE : DRAIN);
        default: state_q <= IDLE;
      endcase
    end
endmodule
